// File: rtl/tx_arbiter.sv
// Four-way round-robin arbiter feeding a UART-style transmitter: captures one byte,
// frames it as start/data/stop, strobes the parallel load, then waits for char_sent.
module tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  ack,
    output logic [9:0]  frame_out,
    output logic        load_n,
    output logic        t_enable,
    input  logic        char_sent,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  sent_count
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StSend = 2'd2;
    localparam logic [1:0] StGap  = 2'd3;

    localparam logic        GapNone     = (GAP_CYCLES == 0);
    localparam logic [11:0] TimeoutLast = 12'(TIMEOUT - 1);
    localparam logic [7:0]  GapLast     = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [9:0]  frame_q, frame_d;
    logic [11:0] tcnt_q, tcnt_d;
    logic [7:0]  gcnt_q, gcnt_d;
    logic [7:0]  count_q, count_d;

    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic        leave_send;

    // Round-robin search starting one above the previous winner.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        frame_d     = frame_q;
        tcnt_d      = tcnt_q;
        gcnt_d      = gcnt_q;
        count_d     = count_q;
        timeout_err = 1'b0;
        leave_send  = 1'b0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StLoad;
                    last_d  = winner;
                    frame_d = {1'b1, data_in[{winner, 3'b000} +: 8], 1'b0};
                end
            end
            StLoad: begin
                state_d = StSend;
                tcnt_d  = '0;
            end
            StSend: begin
                // A completed character beats a simultaneous timeout.
                if (char_sent) begin
                    count_d    = count_q + 8'd1;
                    leave_send = 1'b1;
                end else if (tcnt_q == TimeoutLast) begin
                    timeout_err = 1'b1;
                    leave_send  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 12'd1;
                end
                if (leave_send) begin
                    state_d = GapNone ? StIdle : StGap;
                    tcnt_d  = '0;
                    gcnt_d  = '0;
                end
            end
            StGap: begin
                if (gcnt_q == GapLast) begin
                    state_d = StIdle;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 2'd3;
            frame_q <= 10'h3FF;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            frame_q <= frame_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            count_q <= count_d;
        end
    end

    // last_q already holds the winner while in LOAD.
    always_comb begin
        ack = '0;
        if (state_q == StLoad) begin
            ack = 4'b0001 << last_q;
        end
    end

    assign load_n     = (state_q != StLoad);
    assign t_enable   = (state_q == StSend);
    assign busy       = (state_q != StIdle);
    assign frame_out  = frame_q;
    assign sent_count = count_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized bench for tx_arbiter with a transaction-level reference model
// (round-robin pick, frame formula, character counter) and a second zero-gap instance.
module tb_tx_arbiter;

    localparam int Gap  = 16;
    localparam int Tmo  = 255;
    localparam int Tmo0 = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic [9:0]  frame_out;
    logic        load_n;
    logic        t_enable;
    logic        char_sent;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  sent_count;

    logic        reset0;
    logic [3:0]  req0;
    logic [31:0] data0;
    logic [3:0]  ack0;
    logic [9:0]  frame0;
    logic        load_n0;
    logic        t_enable0;
    logic        char_sent0;
    logic        busy0;
    logic        timeout_err0;
    logic [7:0]  sent_count0;

    int checks = 0;
    int passes = 0;
    int m_last;
    int m_count;

    always #5 clk = ~clk;

    tx_arbiter #(.GAP_CYCLES(Gap), .TIMEOUT(Tmo)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
        .frame_out(frame_out), .load_n(load_n), .t_enable(t_enable),
        .char_sent(char_sent), .busy(busy), .timeout_err(timeout_err),
        .sent_count(sent_count)
    );

    tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT(Tmo0)) dut0 (
        .clk(clk), .reset(reset0), .req(req0), .data_in(data0), .ack(ack0),
        .frame_out(frame0), .load_n(load_n0), .t_enable(t_enable0),
        .char_sent(char_sent0), .busy(busy0), .timeout_err(timeout_err0),
        .sent_count(sent_count0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One full character: IDLE grant -> LOAD -> SEND (char_sent on cycle send_len, 0 = never)
    // -> GAP -> IDLE. Assumes the DUT is in IDLE on entry.
    task automatic do_char(input logic [3:0] r, input logic [31:0] d, input int send_len,
                           input bit hold);
        int w;
        int k;
        bit done;
        bit cs;
        bit exp_to;
        logic [9:0] ef;
        w = rr_pick(r);
        ef = {1'b1, d[8*w +: 8], 1'b0};
        m_last = w;
        req = r;
        data_in = d;
        tick();
        checks++;
        if ({ack, load_n, t_enable, busy} !== {4'(1 << w), 1'b0, 1'b0, 1'b1})
            $display("FAIL load_phase: got ack=%b load_n=%b t_en=%b busy=%b want ack=%b 0 0 1",
                     ack, load_n, t_enable, busy, 4'(1 << w));
        else passes++;
        checks++;
        if (frame_out !== ef)
            $display("FAIL frame_capture: got %b want %b", frame_out, ef);
        else passes++;
        if (!hold) begin
            req = 4'($urandom);
            data_in = $urandom;
        end
        tick();
        k = 1;
        done = 1'b0;
        while (!done) begin
            cs = (k == send_len);
            char_sent = cs;
            #1;
            exp_to = (k == Tmo) && !cs;
            checks++;
            if ({ack, load_n, t_enable, busy, timeout_err, frame_out} !==
                {4'b0, 1'b1, 1'b1, 1'b1, exp_to, ef})
                $display("FAIL send_phase k=%0d: got ack=%b ld=%b te=%b busy=%b to=%b fr=%b want to=%b fr=%b",
                         k, ack, load_n, t_enable, busy, timeout_err, frame_out, exp_to, ef);
            else passes++;
            done = cs || (k == Tmo);
            if (cs) m_count = (m_count + 1) % 256;
            tick();
            if (!hold) begin
                req = 4'($urandom);
                data_in = $urandom;
            end
            k++;
        end
        char_sent = 1'b0;
        checks++;
        if (sent_count !== 8'(m_count))
            $display("FAIL sent_count: got %0d want %0d", sent_count, m_count);
        else passes++;
        for (int g = 1; g <= Gap; g++) begin
            char_sent = 1'($urandom);
            #1;
            checks++;
            if ({ack, load_n, t_enable, busy, timeout_err} !== {4'b0, 1'b1, 1'b0, 1'b1, 1'b0})
                $display("FAIL gap_phase g=%0d: got ack=%b ld=%b te=%b busy=%b to=%b", g,
                         ack, load_n, t_enable, busy, timeout_err);
            else passes++;
            tick();
        end
        char_sent = 1'b0;
        if (!hold) req = 4'b0;
        checks++;
        if ({busy, t_enable, load_n, sent_count} !== {1'b0, 1'b0, 1'b1, 8'(m_count)})
            $display("FAIL idle_after_gap: got busy=%b te=%b ld=%b cnt=%0d want 0 0 1 %0d",
                     busy, t_enable, load_n, sent_count, m_count);
        else passes++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req = 4'b0;
        data_in = '0;
        char_sent = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_last = 3;
        m_count = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({load_n, t_enable, ack, busy, timeout_err, frame_out, sent_count} !==
            {1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 10'h3FF, 8'd0})
            $display("FAIL reset_values: got ld=%b te=%b ack=%b busy=%b to=%b fr=%h cnt=%0d",
                     load_n, t_enable, ack, busy, timeout_err, frame_out, sent_count);
        else passes++;
        tick();
        checks++;
        if ({busy, ack} !== {1'b0, 4'b0})
            $display("FAIL idle_no_req: got busy=%b ack=%b", busy, ack);
        else passes++;
    endtask

    task automatic test_first_char();
        do_char(4'b0001, {24'($urandom), 8'hA5}, 5, 1'b0);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) begin
            do_char(4'b1111, $urandom, int'($urandom_range(1, 6)), 1'b1);
        end
        req = 4'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        do_char(4'b0001, $urandom, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            if (r == 4'b0) begin
                req = 4'b0;
                tick();
                checks++;
                if ({busy, ack} !== {1'b0, 4'b0})
                    $display("FAIL idle_no_req: got busy=%b ack=%b", busy, ack);
                else passes++;
            end else begin
                do_char(r, $urandom, int'($urandom_range(1, 30)), 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        req = 4'b1000;
        data_in = $urandom;
        tick();
        req = 4'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last = 3;
        m_count = 0;
        checks++;
        if ({t_enable, busy, frame_out, sent_count} !== {1'b0, 1'b0, 10'h3FF, 8'd0})
            $display("FAIL reset_mid_send: got te=%b busy=%b fr=%h cnt=%0d",
                     t_enable, busy, frame_out, sent_count);
        else passes++;
        do_char(4'b0100, $urandom, int'($urandom_range(1, 10)), 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            do_char(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(1, 3)), 1'b0);
        end
        checks++;
        if (sent_count !== 8'd0)
            $display("FAIL count_wrap: got %0d want 0", sent_count);
        else passes++;
    endtask

    task automatic test_gap0();
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        req0 = 4'b0010;
        data0 = $urandom;
        tick();
        checks++;
        if ({ack0, load_n0} !== {4'b0010, 1'b0})
            $display("FAIL gap0_load: got ack=%b ld=%b want 0010 0", ack0, load_n0);
        else passes++;
        req0 = 4'b0;
        tick();
        for (int k = 1; k <= Tmo0; k++) begin
            char_sent0 = (k == Tmo0);
            #1;
            checks++;
            if ({t_enable0, timeout_err0} !== {1'b1, 1'b0})
                $display("FAIL gap0_tie k=%0d: got te=%b to=%b want 1 0", k, t_enable0,
                         timeout_err0);
            else passes++;
            tick();
        end
        char_sent0 = 1'b0;
        checks++;
        if ({busy0, sent_count0} !== {1'b0, 8'd1})
            $display("FAIL gap0_tie_exit: got busy=%b cnt=%0d want 0 1", busy0, sent_count0);
        else passes++;
        req0 = 4'b0100;
        tick();
        checks++;
        if (ack0 !== 4'b0100)
            $display("FAIL gap0_load2: got ack=%b want 0100", ack0);
        else passes++;
        req0 = 4'b0;
        tick();
        for (int k = 1; k <= Tmo0; k++) begin
            #1;
            checks++;
            if ({t_enable0, timeout_err0} !== {1'b1, 1'(k == Tmo0)})
                $display("FAIL gap0_timeout k=%0d: got te=%b to=%b want 1 %b", k, t_enable0,
                         timeout_err0, 1'(k == Tmo0));
            else passes++;
            tick();
        end
        checks++;
        if ({busy0, timeout_err0, sent_count0} !== {1'b0, 1'b0, 8'd1})
            $display("FAIL gap0_timeout_exit: got busy=%b to=%b cnt=%0d want 0 0 1",
                     busy0, timeout_err0, sent_count0);
        else passes++;
    endtask

    initial begin
        reset0 = 1'b1;
        req0 = 4'b0;
        data0 = '0;
        char_sent0 = 1'b0;
        test_reset();
        test_first_char();
        test_round_robin();
        test_timeout();
        test_random();
        test_reset_mid_send();
        test_wrap();
        test_gap0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
